// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch stage: PC generator, synchronous-IMEM request port and a
//   DEPTH-entry queue of {pc, inst} pairs presented to decode over valid/ready.
//   A branch redirect flushes the queue and kills the IMEM response in flight.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous reset, active-low (0 = reset)
//   redirect_valid  taken branch/jump, highest priority
//   redirect_addr   new fetch PC, used as-is
//   imem_en         IMEM read strobe
//   imem_addr       IMEM read address (registered fetch PC)
//   imem_rdata      IMEM data, valid exactly one cycle after imem_en
//   out_valid       queue head valid
//   out_ready       decode accepts head
//   out_pc          PC of head instruction (0 while the queue is empty)
//   out_inst        head instruction (0 while the queue is empty)
//   queue_count     entries held
module if_fetch_queue #(
    parameter int unsigned        ADDR_W   = 12,
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_addr,
    output logic                       imem_en,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INST_W-1:0]          imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit;

    // Credit counts held entries plus the response still in flight, so a
    // response can never arrive into a full queue. Pops in the same cycle are
    // deliberately not credited to keep imem_en off the out_ready path.
    always_comb begin
        credit  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        imem_en = rst && !redirect_valid && (credit < CREDIT_MAX);
        push    = inflight && !redirect_valid;
        pop     = out_valid && out_ready;
    end

    assign imem_addr   = fetch_pc;
    assign out_valid   = (count != '0);
    assign queue_count = count;
    assign out_pc      = out_valid ? pc_mem[head]   : '0;
    assign out_inst    = out_valid ? inst_mem[head] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
            end
            if (redirect_valid) begin
                // Flush; a concurrent handshake is treated as consumed.
                fetch_pc <= redirect_addr;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
            end
        end
    end

    // Storage has no reset; empty-queue outputs are gated above instead.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            pc_mem[tail]   <= inflight_pc;
            inst_mem[tail] <= imem_rdata;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst) push |-> (count != FULL)
    );

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [11:0] redirect_addr;
    logic        out_ready;

    logic        imem_en;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [11:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  queue_count;

    // second instance exercising a non-zero reset PC that wraps
    logic        w_imem_en;
    logic [11:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_out_valid;
    logic [11:0] w_out_pc;
    logic [31:0] w_out_inst;
    logic [2:0]  w_queue_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [11:0] a);
        return {a ^ 12'hA5C, 8'h3C, a};
    endfunction

    // synchronous IMEM models: data one cycle after the strobe, garbage otherwise
    always @(posedge clk) imem_rdata   <= imem_en   ? inst_of(imem_addr)   : 32'($urandom);
    always @(posedge clk) w_imem_rdata <= w_imem_en ? inst_of(w_imem_addr) : 32'($urandom);

    if_fetch_queue #(.ADDR_W(12), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(12'h000), .PC_STEP(4)) u_dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .queue_count(queue_count)
    );

    if_fetch_queue #(.ADDR_W(12), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(12'hFF8), .PC_STEP(4)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .redirect_valid(1'b0), .redirect_addr(12'h000),
        .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_pc(w_out_pc), .out_inst(w_out_inst), .queue_count(w_queue_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a queue of PCs (instruction derived from PC), one
    // outstanding request, and the next fetch PC.
    logic [11:0] mq[$];
    bit          m_infl;
    logic [11:0] m_ipc;
    logic [11:0] m_fpc;
    bit          m_fresh;
    bit          model_ok = 1'b0;

    bit          collect = 1'b0;
    logic [11:0] wq[$];

    task automatic step(input logic r, input logic rd, input logic [11:0] ra, input logic rdy);
        bit e_valid, e_en;
        int e_count;
        @(negedge clk);
        rst = r; redirect_valid = rd; redirect_addr = ra; out_ready = rdy;
        #1;
        e_count = mq.size();
        e_valid = (e_count != 0);
        e_en    = r && !rd && ((e_count + int'(m_infl)) < DEPTH);
        if (model_ok) begin
            check("imem_en", 64'(imem_en), 64'(e_en));
            if (e_en) check("imem_addr", 64'(imem_addr), 64'(m_fpc));
            check("out_valid", 64'(out_valid), 64'(e_valid));
            check("queue_count", 64'(queue_count), 64'(e_count));
            if (e_valid) begin
                check("out_pc", 64'(out_pc), 64'(mq[0]));
                check("out_inst", 64'(out_inst), 64'(inst_of(mq[0])));
            end else if (m_fresh) begin
                check("out_pc_reset", 64'(out_pc), 64'd0);
                check("out_inst_reset", 64'(out_inst), 64'd0);
            end
        end
        if (collect && w_out_valid) wq.push_back(w_out_pc);
        // state update for the coming rising edge
        if (!r) begin
            mq.delete();
            m_infl   = 1'b0;
            m_fpc    = 12'h000;
            m_fresh  = 1'b1;
            model_ok = 1'b1;
        end else if (rd) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = ra;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_infl) begin
                mq.push_back(m_ipc);
                m_fresh = 1'b0;
            end
            if (e_en) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 12'd4;
            end
            m_infl = e_en;
        end
    endtask

    initial begin
        logic [11:0] exp_wrap [4];
        exp_wrap = '{12'hFF8, 12'hFFC, 12'h000, 12'h004};
        rst = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b1;

        // reset, then free-running stream (also collect the wrap instance)
        repeat (3) step(1'b0, 1'b0, 12'h000, 1'b1);
        collect = 1'b1;
        repeat (20) step(1'b1, 1'b0, 12'h000, 1'b1);
        collect = 1'b0;
        if (wq.size() < 4) check("wrap_count", 64'(wq.size()), 64'd4);
        else for (int i = 0; i < 4; i++) check($sformatf("wrap_pc%0d", i), 64'(wq[i]), 64'(exp_wrap[i]));

        // stall until full, then release
        repeat (10) step(1'b1, 1'b0, 12'h000, 1'b0);
        repeat (12) step(1'b1, 1'b0, 12'h000, 1'b1);

        // redirect in a steady stream
        step(1'b1, 1'b1, 12'h200, 1'b1);
        repeat (8) step(1'b1, 1'b0, 12'h000, 1'b1);

        // full queue, handshake and redirect together; then back-to-back redirects
        repeat (8) step(1'b1, 1'b0, 12'h000, 1'b0);
        step(1'b1, 1'b1, 12'h040, 1'b1);
        repeat (6) step(1'b1, 1'b0, 12'h000, 1'b1);
        step(1'b1, 1'b1, 12'h100, 1'b1);
        step(1'b1, 1'b1, 12'h300, 1'b1);
        repeat (6) step(1'b1, 1'b0, 12'h000, 1'b1);

        // PC wrap on the main instance through a redirect
        step(1'b1, 1'b1, 12'hFF4, 1'b1);
        repeat (8) step(1'b1, 1'b0, 12'h000, 1'b1);

        // reset with a full queue and a response in flight
        repeat (8) step(1'b1, 1'b0, 12'h000, 1'b0);
        step(1'b0, 1'b0, 12'h000, 1'b0);
        repeat (6) step(1'b1, 1'b0, 12'h000, 1'b1);

        // randomized traffic
        repeat (800) begin
            logic r, rd, rdy;
            logic [11:0] ra;
            r   = ($urandom_range(0, 99) != 0);
            rd  = ($urandom_range(0, 14) == 0);
            ra  = 12'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rd, ra, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
